// File: rtl/fetch_ctrl.sv
// Instruction fetch stage: PC, IF/ID pipeline register and HLT freeze.
// Optional stall/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        IF_Flush,
  input  logic [15:0] br_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] IF_ID_Inst,
  output logic [15:0] IF_ID_PCPlus2,
  output logic        IF_ID_valid,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] ifIdInst_r;
  logic [15:0] ifIdPcPlus2_r;
  logic        ifIdValid_r;
  logic        halted_r;

  logic [15:0] pcPlus2_s;
  logic [15:0] brAligned_s;
  logic        isHlt_s;

  assign pcPlus2_s   = pc_r + 16'd2;
  assign brAligned_s = br_target & 16'hFFFE;
  assign isHlt_s     = (imem_data[15:12] == 4'hF);

  // Fetch FSM: PC, IF/ID register and the registered halted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      pc_r          <= 16'h0000;
      ifIdInst_r    <= 16'h0000;
      ifIdPcPlus2_r <= 16'h0000;
      ifIdValid_r   <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (stall) begin
            pc_r <= pc_r;
          end else if (IF_Flush) begin
            pc_r          <= brAligned_s;
            ifIdInst_r    <= 16'h0000;
            ifIdPcPlus2_r <= 16'h0000;
            ifIdValid_r   <= 1'b0;
          end else begin
            ifIdInst_r    <= imem_data;
            ifIdPcPlus2_r <= pcPlus2_s;
            ifIdValid_r   <= 1'b1;
            if (isHlt_s) begin
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pcPlus2_s;
            end
          end
        end
        HALTED: begin
          // Only reset leaves HALTED; the decode stage drains with bubbles
          if (stall) begin
            pc_r <= pc_r;
          end else begin
            ifIdInst_r    <= 16'h0000;
            ifIdPcPlus2_r <= 16'h0000;
            ifIdValid_r   <= 1'b0;
          end
        end
        default: begin
          state_r  <= RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stallCnt_r;
  logic [15:0] flushCnt_r;
  logic        flushApplies_s;

  assign flushApplies_s = (state_r == RUN) && !stall && IF_Flush;

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_r <= 16'h0000;
      flushCnt_r <= 16'h0000;
    end else begin
      if (stall && (stallCnt_r != 16'hFFFF)) begin
        stallCnt_r <= stallCnt_r + 16'd1;
      end else begin
        stallCnt_r <= stallCnt_r;
      end
      if (flushApplies_s && (flushCnt_r != 16'hFFFF)) begin
        flushCnt_r <= flushCnt_r + 16'd1;
      end else begin
        flushCnt_r <= flushCnt_r;
      end
    end
  end

  assign stall_cnt = stallCnt_r;
  assign flush_cnt = flushCnt_r;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

  assign imem_addr     = pc_r;
  assign IF_ID_Inst    = ifIdInst_r;
  assign IF_ID_PCPlus2 = ifIdPcPlus2_r;
  assign IF_ID_valid   = ifIdValid_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a fetch-stage reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        IF_Flush = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] IF_ID_Inst;
  logic [15:0] IF_ID_PCPlus2;
  logic        IF_ID_valid;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int passCnt = 0;
  int totalCnt = 0;
  bit perfEn;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .IF_Flush(IF_Flush), .br_target(br_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .IF_ID_Inst(IF_ID_Inst),
    .IF_ID_PCPlus2(IF_ID_PCPlus2), .IF_ID_valid(IF_ID_valid), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Program image: HLT at 0x0020, otherwise an ADD tagged with its own address
  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (a == 16'h0020) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  assign imem_data = memWord(imem_addr);

  // Reference model state
  logic [15:0] mPc, mInst, mPc2, mStall, mFlush;
  logic        mValid, mHalted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPc <= 16'd0; mInst <= 16'd0; mPc2 <= 16'd0; mValid <= 1'b0;
      mHalted <= 1'b0; mStall <= 16'd0; mFlush <= 16'd0;
    end else begin
      if (perfEn && stall && mStall != 16'hFFFF) mStall <= mStall + 16'd1;
      if (!stall) begin
        if (mHalted) begin
          mInst <= 16'd0; mPc2 <= 16'd0; mValid <= 1'b0;
        end else if (IF_Flush) begin
          mPc <= {br_target[15:1], 1'b0};
          mInst <= 16'd0; mPc2 <= 16'd0; mValid <= 1'b0;
          if (perfEn && mFlush != 16'hFFFF) mFlush <= mFlush + 16'd1;
        end else begin
          mInst <= memWord(mPc);
          mPc2 <= mPc + 16'd2;
          mValid <= 1'b1;
          if (memWord(mPc) >= 16'hF000) mHalted <= 1'b1;
          else mPc <= mPc + 16'd2;
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("pc", imem_addr, mPc);
    check("inst", IF_ID_Inst, mInst);
    check("pcplus2", IF_ID_PCPlus2, mPc2);
    check("valid", {15'd0, IF_ID_valid}, {15'd0, mValid});
    check("halted", {15'd0, halted}, {15'd0, mHalted});
    check("stall_cnt", stall_cnt, mStall);
    check("flush_cnt", flush_cnt, mFlush);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_pc"}, imem_addr, 16'h0000);
    check({tag, "_inst"}, IF_ID_Inst, 16'h0000);
    check({tag, "_valid"}, {15'd0, IF_ID_valid}, 16'h0000);
    check({tag, "_halted"}, {15'd0, halted}, 16'h0000);
    check({tag, "_scnt"}, stall_cnt, 16'h0000);
    check({tag, "_fcnt"}, flush_cnt, 16'h0000);
  endtask

  initial begin
`ifdef FETCH_PERF_CNT_EN
    perfEn = 1'b1;
`else
    perfEn = 1'b0;
`endif
    step(2);
    checkReset("rst0");
    rst = 1'b0;
    // Sequential fetch from 0
    step(1);
    check("seq1_pc", imem_addr, 16'h0002);
    check("seq1_inst", IF_ID_Inst, 16'h1000);
    check("seq1_p2", IF_ID_PCPlus2, 16'h0002);
    check("seq1_valid", {15'd0, IF_ID_valid}, 16'h0001);
    step(1);
    check("seq2_p2", IF_ID_PCPlus2, 16'h0004);
    step(1);
    check("seq3_p2", IF_ID_PCPlus2, 16'h0006);
    step(1);
    check("seq4_pc", imem_addr, 16'h0008);
    // Three-cycle stall at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_pc", imem_addr, 16'h0008);
      check("stall_inst", IF_ID_Inst, 16'h1006);
      check("stall_p2", IF_ID_PCPlus2, 16'h0008);
    end
    check("stall_cnt3", stall_cnt, perfEn ? 16'd3 : 16'd0);
    stall = 1'b0;
    step(4);
    check("pre_br_pc", imem_addr, 16'h0010);
    // Taken branch with odd target
    IF_Flush = 1'b1; br_target = 16'h0041;
    step(1);
    check("br_pc", imem_addr, 16'h0040);
    check("br_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check("br_inst", IF_ID_Inst, 16'h0000);
    check("br_fcnt", flush_cnt, perfEn ? 16'd1 : 16'd0);
    IF_Flush = 1'b0;
    step(2);
    check("post_br_pc", imem_addr, 16'h0044);
    // Stall and flush together: stall wins
    stall = 1'b1; IF_Flush = 1'b1; br_target = 16'h0100;
    step(1);
    check("sf_pc", imem_addr, 16'h0044);
    check("sf_inst", IF_ID_Inst, 16'h1042);
    check("sf_fcnt", flush_cnt, perfEn ? 16'd1 : 16'd0);
    // Branch to the HLT
    stall = 1'b0; br_target = 16'h0020;
    step(1);
    IF_Flush = 1'b0;
    step(1);
    check("hlt_inst", IF_ID_Inst, 16'hF000);
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_pc", imem_addr, 16'h0020);
    step(1);
    check("hlt_bubble_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check("hlt_bubble_inst", IF_ID_Inst, 16'h0000);
    IF_Flush = 1'b1; br_target = 16'h0080;
    step(2);
    check("hlt_flush_pc", imem_addr, 16'h0020);
    check("hlt_flush_halted", {15'd0, halted}, 16'h0001);
    IF_Flush = 1'b0; stall = 1'b1;
    step(1);
    // Reset while halted and stalled
    rst = 1'b1;
    step(1);
    checkReset("rst_hlt");
    rst = 1'b0; stall = 1'b0;
    // Wrap at top of memory (also checks target bit 0 is dropped)
    IF_Flush = 1'b1; br_target = 16'hFFFF;
    step(1);
    check("wrap_pc0", imem_addr, 16'hFFFE);
    IF_Flush = 1'b0;
    step(1);
    check("wrap_pc", imem_addr, 16'h0000);
    check("wrap_p2", IF_ID_PCPlus2, 16'h0000);
    check("wrap_inst", IF_ID_Inst, 16'h1FFE);
    stall = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    checkReset("rst_stall");
    rst = 1'b0; stall = 1'b0;
    step(3);
    check("restart_pc", imem_addr, 16'h0006);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, HDU hold request for PC and IF/ID.
REQ-004 SHALL have port IF_Flush, input, 1, HDU flush request: branch taken in ID.
REQ-005 SHALL have port br_target, input, 16, redirect address, valid with IF_Flush.
REQ-006 SHALL have port imem_addr, output, 16, instruction memory address, equal to PC.
REQ-007 SHALL have port imem_data, input, 16, instruction returned combinationally for imem_addr.
REQ-008 SHALL have port IF_ID_Inst, output, 16, registered instruction to decode.
REQ-009 SHALL have port IF_ID_PCPlus2, output, 16, registered PC+2 of IF_ID_Inst.
REQ-010 SHALL have port IF_ID_valid, output, 1, 0 marks IF_ID_Inst as a bubble.
REQ-011 SHALL have port halted, output, 1, fetch frozen by HLT.
REQ-012 SHALL have ports stall_cnt and flush_cnt, output, 16 each, performance counters (see Configuration).

Function
REQ-013 SHALL implement two states: RUN and HALTED.
REQ-014 In RUN with stall=1: PC, IF_ID_Inst, IF_ID_PCPlus2, IF_ID_valid hold; IF_Flush ignored that cycle.
REQ-015 In RUN with stall=0 and IF_Flush=1: PC<=br_target; IF_ID_Inst<=16'h0000; IF_ID_valid<=0; IF_ID_PCPlus2<=0.
REQ-016 In RUN with stall=0, IF_Flush=0, imem_data[15:12]!=4'hF: IF_ID_Inst<=imem_data; IF_ID_PCPlus2<=PC+2; IF_ID_valid<=1; PC<=PC+2.
REQ-017 In RUN with stall=0, IF_Flush=0, imem_data[15:12]==4'hF (HLT): HLT latched into IF/ID as in REQ-016; PC holds; next state HALTED.
REQ-018 PC+2 SHALL be 16-bit modulo: 16'hFFFE wraps to 16'h0000.
REQ-019 In HALTED with stall=1: IF/ID and PC hold.
REQ-020 In HALTED with stall=0: IF/ID loads bubble (16'h0000, valid=0); PC holds.
REQ-021 In HALTED, IF_Flush SHALL be ignored; HALTED exits only via rst.
REQ-022 halted SHALL be 1 exactly when state is HALTED (registered, no combinational path).
REQ-023 imem_addr SHALL equal PC combinationally; no other output combinational from inputs.
REQ-024 br_target[0] SHALL be forced to 0 on load (halfword alignment).

Reset
REQ-025 On rst=1, asynchronously: PC=0, IF_ID_Inst=16'h0000, IF_ID_PCPlus2=0, IF_ID_valid=0, state=RUN, halted=0, stall_cnt=0, flush_cnt=0.
REQ-026 First fetch SHALL occur on the first posedge after rst deasserts, from address 0.
REQ-027 rst asserted in HALTED or mid-stall SHALL return to REQ-025 values irrespective of other inputs.

Configuration
REQ-028 With macro FETCH_PERF_CNT_EN defined: stall_cnt increments each cycle stall=1; flush_cnt increments each cycle REQ-015 applies; both saturate at 16'hFFFF.
REQ-029 Without FETCH_PERF_CNT_EN: stall_cnt and flush_cnt tied to 16'h0000, no counter registers synthesized; all other behaviour identical.

Verification
REQ-030 Sequential fetch: rst release, imem returns ADDs, no stall/flush -> imem_addr 0,2,4,6; IF_ID_PCPlus2 2,4,6; IF_ID_valid=1 from cycle 1.
REQ-031 Stall: stall=1 for 3 cycles at PC=0x0008 -> PC and IF/ID unchanged 3 cycles; stall_cnt=3 with FETCH_PERF_CNT_EN, 0 without.
REQ-032 Branch: IF_Flush=1, br_target=0x0041 at PC=0x0010 -> next PC=0x0040, IF_ID_valid=0, IF_ID_Inst=0; flush_cnt=1 (macro on).
REQ-033 Stall+flush same cycle: stall=1, IF_Flush=1 -> all state holds, flush_cnt unchanged.
REQ-034 HLT: imem_data=16'hF000 at PC=0x0020 -> IF_ID_Inst=F000, halted=1 next cycle, then bubbles, PC stays 0x0020; IF_Flush later ignored; rst clears halted.
REQ-035 Wrap: PC=0xFFFE, no stall -> next PC=0x0000, IF_ID_PCPlus2=0x0000.
